// File: rtl/truth_table_checker.sv
// truth_table_checker: drives every input vector of an N-input gate in
// ascending order, holds each one for a settle window, samples the gate
// output on the last cycle of the window and compares it against EXPECTED.
// Reports busy/done, a mismatch count and an overall pass flag.
// Optional feature: define TRUTH_TABLE_CHECKER_FIRST_FAIL_EN to add the
// first_fail_valid / first_fail_idx outputs that remember the first
// mismatching vector of a sweep.
module truth_table_checker #(
  parameter int unsigned N_INPUTS      = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [(1<<N_INPUTS)-1:0] EXPECTED = 4'b0111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dut_out,
  output logic [N_INPUTS-1:0] stim_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   err_count
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
  ,
  output logic                first_fail_valid,
  output logic [N_INPUTS-1:0] first_fail_idx
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_INPUTS-1:0] STIM_LAST   = '1;
  localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] stim_q, stim_d;
  logic [7:0]          settle_q, settle_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic                pass_q, pass_d;

`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
  logic                ff_valid_q, ff_valid_d;
  logic [N_INPUTS-1:0] ff_idx_q, ff_idx_d;
`endif

  // A new sweep may only begin when no sweep is in progress.
  logic accept;
  logic sample;
  logic last_vec;
  logic mismatch;

  assign accept   = start && (state_q != RUN);
  assign sample   = (state_q == RUN) && (settle_q == SETTLE_LAST);
  assign last_vec = (stim_q == STIM_LAST);
  assign mismatch = sample && (dut_out != EXPECTED[stim_q]);

  // State and datapath registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stim_q     <= '0;
      settle_q   <= '0;
      err_q      <= '0;
      pass_q     <= 1'b0;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      settle_q   <= settle_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
      ff_valid_q <= ff_valid_d;
      ff_idx_q   <= ff_idx_d;
`endif
    end
  end

  // Next state: start launches a sweep, the last sampling edge ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (sample && last_vec) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: vector stepping, settle timing, mismatch counting and verdict.
  always_comb begin
    stim_d   = stim_q;
    settle_d = settle_q;
    err_d    = err_q;
    pass_d   = pass_q;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
    ff_valid_d = ff_valid_q;
    ff_idx_d   = ff_idx_q;
`endif
    if (accept) begin
      stim_d   = '0;
      settle_d = '0;
      err_d    = '0;
      pass_d   = 1'b0;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
      ff_valid_d = 1'b0;
      ff_idx_d   = '0;
`endif
    end else if (state_q == RUN) begin
      if (sample) begin
        err_d = err_q + (N_INPUTS+1)'(mismatch);
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
        if (mismatch && !ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_idx_d   = stim_q;
        end
`endif
        if (last_vec) begin
          pass_d = (err_d == '0);
        end else begin
          stim_d   = stim_q + N_INPUTS'(1);
          settle_d = '0;
        end
      end else begin
        settle_d = settle_q + 8'd1;
      end
    end
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign stim_out  = stim_q;
  assign err_count = err_q;
  assign pass      = pass_q;
`ifdef TRUTH_TABLE_CHECKER_FIRST_FAIL_EN
  assign first_fail_valid = ff_valid_q;
  assign first_fail_idx   = ff_idx_q;
`endif

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-checking stimulus/response stage for the basic-logic-gates library: sits directly upstream of a combinational gate under test (NAND, NOR, XOR, ...).
- Walks every input combination of an N-input gate in ascending binary order, holds each vector for a settle window, samples the gate output and compares it against a parameterised expected truth table.
- Reports busy/done status, a mismatch count and an overall pass flag, replacing hand-written per-gate stimulus sequences with one reusable, synthesizable checker.

Parameters:
- N_INPUTS, 2, number of gate inputs driven; legal range 1..6.
- SETTLE_CYCLES, 2, extra clock cycles each vector is held before sampling; legal range 0..255.
- EXPECTED, 4'b0111, expected truth table, width 2**N_INPUTS; bit i = expected dut_out when stim_out == i (default = 2-input NAND).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a full sweep; sampled only in IDLE or DONE.
- dut_out  input  1  output of the gate under test, combinational from stim_out.
- stim_out  output  N_INPUTS  vector driven to the gate; stim_out[N_INPUTS-1] = first input (a), bit 0 = last input.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high (level) from sweep completion until next accepted start or reset.
- pass  output  1  valid when done=1; 1 iff err_count == 0.
- err_count  output  N_INPUTS+1  number of mismatching vectors in the current/last sweep.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values, asserted asynchronously and held until rst_n deasserts: state=IDLE, stim_out=0, busy=0, done=0, pass=0, err_count=0, settle counter=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge -> RUN; stim_out=0, settle counter=0, err_count=0, busy=1, done=0.
- RUN: each vector held exactly SETTLE_CYCLES+1 cycles. On the last cycle of the window, dut_out is compared with EXPECTED[stim_out]; on mismatch err_count increments at that edge.
- RUN, last vector (stim_out = 2**N_INPUTS-1): at the sampling edge -> DONE, busy=0, done=1, pass=(final err_count==0, including this vector's result); stim_out holds the last vector. Otherwise stim_out increments and the settle counter clears.
- Latency: done rises 2**N_INPUTS*(SETTLE_CYCLES+1) cycles after the edge that accepted start (default: 12 cycles).
- start is ignored while busy=1. A start held high continuously re-triggers a sweep on the first edge in DONE.
- DONE: outputs are stable. start=1 -> identical to start from IDLE (err_count clears, done drops, pass=0).
- err_count cannot overflow: its maximum is 2**N_INPUTS, which fits in N_INPUTS+1 bits.
- rst_n low mid-sweep: immediate return to the reset values; no partial result is retained.
- dut_out is compared only at sampling edges; glitches elsewhere in the window have no effect.

Optional Feature:
- Macro: TRUTH_TABLE_CHECKER_FIRST_FAIL_EN.
- Defined:
  - Adds output first_fail_valid (1 bit) and output first_fail_idx (N_INPUTS bits).
  - On the first mismatch of a sweep, first_fail_idx captures stim_out and first_fail_valid sets.
  - Later mismatches do not overwrite them.
  - Both clear on reset and on any accepted start.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Defaults, dut_out = ~(stim_out[1] & stim_out[0]), pulse start -> stim_out steps 0,1,2,3 holding 3 cycles each; done=1 twelve cycles after acceptance; pass=1, err_count=0.
- Defaults, dut_out = AND of inputs -> all 4 vectors mismatch; done=1, err_count=4, pass=0; with macro defined, first_fail_idx=0 and first_fail_valid=1.
- Defaults, dut_out tied to 1 -> err_count=1 (vector 3 only), pass=0; with macro defined, first_fail_idx=3.
- Pulse start, then drop rst_n while stim_out=1 -> outputs return to reset values asynchronously. Release rst_n and start again with a correct NAND -> clean 12-cycle sweep, pass=1.
- Pulse start again at cycle 5 while busy -> no effect, done still at cycle 12. After done, pulse start with dut_out tied to 0 -> err_count clears then ends at 3, pass=0.
- SETTLE_CYCLES=0, N_INPUTS=3, EXPECTED=8'b1001_0110 (3-input XOR), correct XOR model -> 8 vectors one cycle each, done after 8 cycles, pass=1.
